rc6_round_engine: RTL

RC6_ROUND_ENGINE -- requirements
Module: rc6_round_engine

---
 rtl/rc6_pkg.sv | 41 ++++
 rtl/rc6_round_dp.sv | 53 +++++
 rtl/rc6_round_engine.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rc6_pkg.sv
// rc6_pkg -- shared types and helpers for the RC6 round engine.
//   state_e : engine FSM states
//   rotl/rotr : rotate within a w-bit word (w <= 64), amount reduced mod w
//   w_legal : word-size / rotate-constant legality check
package rc6_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ROUND,
        S_POST,
        S_DONE
    } state_e;

    function automatic bit w_legal(int w, int lgw);
        return ((w == 16) || (w == 32) || (w == 64)) && (lgw == $clog2(w));
    endfunction

    // Rotates carry a 64-bit container so one function serves every legal W;
    // callers pass a constant w, so the masks and shifts fold away.
    function automatic logic [63:0] rotl(int w, logic [63:0] x, int amt);
        logic [63:0] mask;
        logic [63:0] xm;
        int          s;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        xm   = x & mask;
        s    = amt % w;
        return ((xm << s) | (xm >> (w - s))) & mask;
    endfunction

    function automatic logic [63:0] rotr(int w, logic [63:0] x, int amt);
        logic [63:0] mask;
        logic [63:0] xm;
        int          s;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        xm   = x & mask;
        s    = amt % w;
        return ((xm >> s) | (xm << (w - s))) & mask;
    endfunction

endpackage

// File: rtl/rc6_round_dp.sv
// rc6_round_dp -- one combinational RC6 round, either direction.
//   a_i..d_i : current words      key_pair : {S[2i+1], S[2i]}
//   enc      : 1 = encrypt round, 0 = decrypt round
//   a_o..d_o : words after the round (including the word rotation)
module rc6_round_dp
    import rc6_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic [W-1:0]   c_i,
    input  logic [W-1:0]   d_i,
    input  logic [2*W-1:0] key_pair,
    input  logic           enc,
    output logic [W-1:0]   a_o,
    output logic [W-1:0]   b_o,
    output logic [W-1:0]   c_o,
    output logic [W-1:0]   d_o
);
    localparam int LGW = $clog2(W);

    logic [W-1:0] s_lo, s_hi, src_b, src_d, fb, fd, t, u, xa, xc;

    always_comb begin
        s_lo = key_pair[W-1:0];
        s_hi = key_pair[2*W-1:W];
        // Decrypt un-rotates the words first, so its B and D are the
        // incoming A and C.
        src_b = enc ? b_i : a_i;
        src_d = enc ? d_i : c_i;
        fb = src_b * {src_b[W-2:0], 1'b1};
        fd = src_d * {src_d[W-2:0], 1'b1};
        t  = W'(rotl(W, 64'(fb), LGW));
        u  = W'(rotl(W, 64'(fd), LGW));
        if (enc) begin
            xa  = a_i ^ t;
            xc  = c_i ^ u;
            a_o = b_i;
            b_o = W'(rotl(W, 64'(xc), int'(t[LGW-1:0]))) + s_hi;
            c_o = d_i;
            d_o = W'(rotl(W, 64'(xa), int'(u[LGW-1:0]))) + s_lo;
        end else begin
            xa  = d_i - s_lo;
            xc  = b_i - s_hi;
            a_o = W'(rotr(W, 64'(xa), int'(u[LGW-1:0]))) ^ t;
            b_o = a_i;
            c_o = W'(rotr(W, 64'(xc), int'(t[LGW-1:0]))) ^ u;
            d_o = c_i;
        end
    end

endmodule

// File: rtl/rc6_round_engine.sv
// rc6_round_engine -- iterative RC6 encrypt/decrypt, one round per cycle.
//   in_valid/in_ready/enc/data_in : block input, {D,C,B,A} packing
//   key_idx -> key_pair            : external round-key lookup (same cycle)
//   out_valid/out_ready/data_out   : result output, held until taken
//   busy                           : high whenever not IDLE
module rc6_round_engine
    import rc6_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      enc,
    input  logic [4*W-1:0]            data_in,
    output logic [$clog2(R+2)-1:0]    key_idx,
    input  logic [2*W-1:0]            key_pair,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*W-1:0]            data_out,
    output logic                      busy
);
    localparam int LGW = $clog2(W);
    localparam int KW  = $clog2(R+2);
    localparam logic [KW-1:0] R_K  = KW'(R);
    localparam logic [KW-1:0] R1_K = KW'(R+1);

    if (!w_legal(W, LGW) || (R < 1) || (R > 255)) begin : g_bad_param
        $error("rc6_round_engine: illegal W or R");
    end

    state_e        state_q, state_d;
    logic [KW-1:0] rc_q, rc_d;
    logic [W-1:0]  a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
    logic [W-1:0]  a_r, b_r, c_r, d_r;
    logic [W-1:0]  s_lo, s_hi;
    logic          enc_q, enc_d, accept;

    assign s_lo = key_pair[W-1:0];
    assign s_hi = key_pair[2*W-1:W];

    rc6_round_dp #(.W(W)) u_dp (
        .a_i(a_q), .b_i(b_q), .c_i(c_q), .d_i(d_q),
        .key_pair(key_pair), .enc(enc_q),
        .a_o(a_r), .b_o(b_r), .c_o(c_r), .d_o(d_r)
    );

    always_comb begin
        in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
        accept   = in_valid && in_ready;
        state_d  = state_q;
        rc_d     = rc_q;
        enc_d    = enc_q;
        {a_d, b_d, c_d, d_d} = {a_q, b_q, c_q, d_q};
        key_idx  = '0;
        case (state_q)
            S_IDLE: ;
            S_PRE: begin
                key_idx = enc_q ? '0 : R1_K;
                if (enc_q) begin
                    b_d = b_q + s_lo;
                    d_d = d_q + s_hi;
                end else begin
                    c_d = c_q - s_hi;
                    a_d = a_q - s_lo;
                end
                rc_d    = KW'(1);
                state_d = S_ROUND;
            end
            S_ROUND: begin
                key_idx = enc_q ? rc_q : (R1_K - rc_q);
                {a_d, b_d, c_d, d_d} = {a_r, b_r, c_r, d_r};
                if (rc_q == R_K) begin
                    rc_d    = '0;
                    state_d = S_POST;
                end else begin
                    rc_d = rc_q + KW'(1);
                end
            end
            S_POST: begin
                key_idx = enc_q ? R1_K : '0;
                if (enc_q) begin
                    a_d = a_q + s_lo;
                    c_d = c_q + s_hi;
                end else begin
                    d_d = d_q - s_hi;
                    b_d = b_q - s_lo;
                end
                state_d = S_DONE;
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Accept only happens in IDLE or in DONE while the result is taken,
        // so it overrides whatever those states chose.
        if (accept) begin
            a_d     = data_in[W-1:0];
            b_d     = data_in[2*W-1:W];
            c_d     = data_in[3*W-1:2*W];
            d_d     = data_in[4*W-1:3*W];
            enc_d   = enc;
            rc_d    = '0;
            state_d = S_PRE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rc_q    <= '0;
            enc_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            enc_q   <= enc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign data_out  = {d_q, c_q, b_q, a_q};

endmodule
